// File: rtl/dcpu16_rarb_pkg.sv
// Shared dcpu16 definitions for the register-file arbiter: requester count,
// arbitration state encodings, register index width and data width.
package dcpu16_rarb_pkg;

  localparam int NREQ   = 2;
  localparam int REG_AW = 3;
  localparam int DATA_W = 16;

  // Arbitration states
  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // Last-grant pointer values
  localparam logic PTR_M0 = 1'b0;
  localparam logic PTR_M1 = 1'b1;

endpackage

// File: rtl/dcpu16_rarb.sv
// Two-master register-file arbiter for the dcpu16. The CPU (m0) and the
// debug port (m1) share one register-file access per cycle. Issue is
// combinational; the response valid follows its grant by one enabled cycle
// and read data comes straight from the register file. m1 can hold the
// file exclusively with m1_lock.
module dcpu16_rarb
  import dcpu16_rarb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  // CPU side
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [REG_AW-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic              m0_gnt,
  output logic              m0_rvld,
  output logic [DATA_W-1:0] m0_dat_o,
  // Debug side
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [REG_AW-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic              m1_gnt,
  output logic              m1_rvld,
  output logic [DATA_W-1:0] m1_dat_o,
  // Register file
  output logic [REG_AW-1:0] rra,
  output logic [REG_AW-1:0] rwa,
  output logic [DATA_W-1:0] rwd,
  output logic              rwe,
  output logic              rena,
  input  logic [DATA_W-1:0] rrd
);

  logic [0:0]      state;
  logic [0:0]      state_nxt;
  logic            last;
  logic            last_nxt;
  logic [NREQ-1:0] vld_p1;
  logic            arb_mode;
  logic            gnt0;
  logic            gnt1;

  // Grant decision: round-robin in ARB, m1 only while the lock is held.
  // Dropping m1_lock releases the lock in the same cycle, so arbitration
  // already follows ARB rules then. Reset and stall suppress all grants.
  always_comb begin
    arb_mode = (state == ST_ARB) || !m1_lock;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    if (rst && ena) begin
      if (arb_mode) begin
        if (m0_req && m1_req) begin
          gnt1 = (last == PTR_M0);
          gnt0 = (last == PTR_M1);
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
      end else begin
        gnt1 = m1_req;
      end
    end
  end

  // Route the winner onto the register-file port.
  always_comb begin
    rra    = gnt1 ? m1_adr : m0_adr;
    rwa    = gnt1 ? m1_adr : m0_adr;
    rwd    = gnt1 ? m1_dat_i : m0_dat_i;
    rwe    = (gnt0 && m0_we) || (gnt1 && m1_we);
    rena   = gnt0 || gnt1;
    m0_gnt = gnt0;
    m1_gnt = gnt1;
  end

  // Next arbitration state and last-grant pointer.
  always_comb begin
    state_nxt = state;
    if (gnt1 && m1_lock) begin
      state_nxt = ST_LOCK;
    end else if (!m1_lock) begin
      state_nxt = ST_ARB;
    end
    last_nxt = last;
    if (gnt0) begin
      last_nxt = PTR_M0;
    end else if (gnt1) begin
      last_nxt = PTR_M1;
    end
  end

  // Control flops; everything holds while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_ARB;
      last   <= PTR_M1;
      vld_p1 <= '0;
    end else if (ena) begin
      state  <= state_nxt;
      last   <= last_nxt;
      vld_p1 <= {gnt1, gnt0};
    end
  end

  // ---- stage p1: response (register file data is valid here) ----
  assign m0_rvld  = vld_p1[0];
  assign m1_rvld  = vld_p1[1];
  assign m0_dat_o = rrd;
  assign m1_dat_o = rrd;

endmodule

// File: tb/tb_dcpu16_rarb.sv
// Bench for dcpu16_rarb: directed scenarios with literal expectations plus
// randomized requester agents checked every cycle against a behavioural
// model of the arbitration and register-file response rules.
module tb_dcpu16_rarb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        m0_req, m0_we;
  logic [2:0]  m0_adr;
  logic [15:0] m0_dat_i;
  logic        m0_gnt, m0_rvld;
  logic [15:0] m0_dat_o;
  logic        m1_req, m1_we, m1_lock;
  logic [2:0]  m1_adr;
  logic [15:0] m1_dat_i;
  logic        m1_gnt, m1_rvld;
  logic [15:0] m1_dat_o;
  logic [2:0]  rra, rwa;
  logic [15:0] rwd;
  logic        rwe, rena;
  logic [15:0] rrd;

  dcpu16_rarb dut (
    .clk(clk), .rst(rst), .ena(ena),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_i(m0_dat_i),
    .m0_gnt(m0_gnt), .m0_rvld(m0_rvld), .m0_dat_o(m0_dat_o),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_adr(m1_adr),
    .m1_dat_i(m1_dat_i), .m1_gnt(m1_gnt), .m1_rvld(m1_rvld), .m1_dat_o(m1_dat_o),
    .rra(rra), .rwa(rwa), .rwd(rwd), .rwe(rwe), .rena(rena), .rrd(rrd)
  );

  always #5 clk = ~clk;

  // Register file stand-in: synchronous, write-first, output held when idle.
  logic [15:0] rf [8];
  always @(posedge clk) begin
    if (rena) begin
      if (rwe) begin
        rf[rwa] <= rwd;
        rrd     <= rwd;
      end else begin
        rrd <= rf[rra];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit          m_locked;
  bit          m_last;
  bit          m_rv0, m_rv1;
  logic [15:0] m_d0, m_d1;
  bit          m_dv0, m_dv1;
  logic [15:0] shadow [8];
  bit          sh_vld [8];
  int          w;

  // Values captured at the last check, for literal expectations
  logic        g0, g1, c_rena, c_rwe, c_rv0, c_rv1;
  logic [15:0] c_d0, c_d1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against the model for the current cycle.
  task automatic check_now();
    if (!rst) begin
      m_locked = 1'b0;
      m_last   = 1'b1;
      m_rv0    = 1'b0;
      m_rv1    = 1'b0;
    end
    w = -1;
    if (rst && ena) begin
      if (m_locked && m1_lock)    w = m1_req ? 1 : -1;
      else if (m0_req && m1_req) w = m_last ? 0 : 1;
      else if (m0_req)           w = 0;
      else if (m1_req)           w = 1;
    end
    chk("m0_gnt", m0_gnt, w == 0);
    chk("m1_gnt", m1_gnt, w == 1);
    chk("rena", rena, w >= 0);
    chk("rwe", rwe, (w == 0) ? m0_we : (w == 1) ? m1_we : 1'b0);
    if (w >= 0) begin
      chk("rra", rra, (w == 1) ? m1_adr : m0_adr);
      chk("rwa", rwa, (w == 1) ? m1_adr : m0_adr);
      chk("rwd", rwd, (w == 1) ? m1_dat_i : m0_dat_i);
    end
    chk("m0_rvld", m0_rvld, m_rv0);
    chk("m1_rvld", m1_rvld, m_rv1);
    if (m_rv0 && m_dv0) chk("m0_dat_o", m0_dat_o, m_d0);
    if (m_rv1 && m_dv1) chk("m1_dat_o", m1_dat_o, m_d1);
    g0 = m0_gnt; g1 = m1_gnt; c_rena = rena; c_rwe = rwe;
    c_rv0 = m0_rvld; c_rv1 = m1_rvld; c_d0 = m0_dat_o; c_d1 = m1_dat_o;
  endtask

  // Advance the model across a rising edge.
  task automatic update_model();
    logic [2:0]  a;
    logic [15:0] v;
    bit          vv;
    if (rst && ena) begin
      m_rv0 = (w == 0);
      m_rv1 = (w == 1);
      if (w >= 0) begin
        a = (w == 1) ? m1_adr : m0_adr;
        if ((w == 1) ? m1_we : m0_we) begin
          v = (w == 1) ? m1_dat_i : m0_dat_i;
          shadow[a] = v;
          sh_vld[a] = 1'b1;
          vv = 1'b1;
        end else begin
          v  = shadow[a];
          vv = sh_vld[a];
        end
        if (w == 1) begin m_d1 = v; m_dv1 = vv; end
        else        begin m_d0 = v; m_dv0 = vv; end
        m_last = (w == 1);
      end
      if (w == 1 && m1_lock) m_locked = 1'b1;
      else if (!m1_lock)     m_locked = 1'b0;
    end
  endtask

  // One clock cycle: inputs already applied at the falling edge.
  task automatic step();
    #1;
    check_now();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) sh_vld[i] = 1'b0;
    rst = 1'b0; ena = 1'b1;
    m0_req = 0; m0_we = 0; m0_adr = 0; m0_dat_i = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_adr = 0; m1_dat_i = 0;
    @(negedge clk);

    // Reset state
    m0_req = 1; m1_req = 1;
    step();
    chk("reset_gnt", {g0, g1, c_rena, c_rwe}, 4'b0000);
    chk("reset_rvld", {c_rv0, c_rv1}, 2'b00);
    m0_req = 0; m1_req = 0;
    rst = 1'b1;

    // m0 write then read-back of register 3
    m0_req = 1; m0_we = 1; m0_adr = 3; m0_dat_i = 16'hBEEF;
    step();
    chk("wr_gnt", {g0, c_rwe}, 2'b11);
    m0_we = 0; m0_dat_i = 16'h0000;
    step();
    chk("rd_gnt", {g0, c_rwe}, 2'b10);
    chk("wr_rvld", c_rv0, 1'b1);
    chk("wr_dat", c_d0, 16'hBEEF);
    m0_req = 0;
    step();
    chk("rd_rvld", c_rv0, 1'b1);
    chk("rd_dat", c_d0, 16'hBEEF);
    step();
    chk("idle_rvld", c_rv0, 1'b0);

    // Contention alternates starting with m0 after reset
    rst = 1'b0;
    step();
    rst = 1'b1;
    m0_req = 1; m1_req = 1; m1_we = 0; m1_lock = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("alternate", {g0, g1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      m0_adr = 3'(i); m1_adr = 3'(7 - i);
    end

    // m1 locked read of register 5 while m0 keeps requesting
    m1_adr = 5; m1_lock = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lock_gnt", {g0, g1}, 2'b01);
    end
    m1_lock = 0; m1_req = 0;
    step();
    chk("unlock_gnt", {g0, g1}, 2'b10);

    // Stall after a grant
    step();
    chk("pre_stall_gnt", g0, 1'b1);
    ena = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_idle", {g0, g1, c_rena}, 3'b000);
      chk("stall_rvld", c_rv0, 1'b1);
    end
    ena = 1; m0_req = 0;
    step();
    chk("resume_rvld", c_rv0, 1'b1);
    step();
    chk("resume_clear", c_rv0, 1'b0);

    // Reset right after an m1 grant
    m1_req = 1; m1_adr = 2;
    #1;
    check_now();
    chk("pre_rst_gnt", g1, 1'b1);
    @(posedge clk);
    update_model();
    #2 rst = 1'b0;
    #1 chk("rst_m1_rvld", m1_rvld, 1'b0);
    @(negedge clk);
    m1_req = 0;
    step();
    chk("rst_no_rvld", {c_rv0, c_rv1}, 2'b00);
    rst = 1'b1;
    step();
    chk("post_rst_no_rvld", {c_rv0, c_rv1}, 2'b00);
    m0_req = 1; m1_req = 1;
    step();
    chk("post_rst_first", {g0, g1}, 2'b10);
    m0_req = 0; m1_req = 0;
    step();

    // Randomized agents
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) != 0);
      ena = ($urandom_range(0, 9) != 0);
      if (!m0_req || g0) begin
        m0_req   = ($urandom_range(0, 9) < 6);
        m0_we    = $urandom_range(0, 1);
        m0_adr   = 3'($urandom_range(0, 7));
        m0_dat_i = 16'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        m0_req = 0;
      end
      if (!m1_req || g1) begin
        m1_req   = ($urandom_range(0, 9) < 5);
        m1_we    = $urandom_range(0, 1);
        m1_adr   = 3'($urandom_range(0, 7));
        m1_dat_i = 16'($urandom);
        m1_lock  = ($urandom_range(0, 3) == 0);
      end else if ($urandom_range(0, 19) == 0) begin
        m1_req = 0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
